// File: rtl/cam_pkg.sv
// Shared constants, state encoding and pixel conversion for the camera capture stage.
package cam_pkg;

  localparam int IMG_W    = 160;
  localparam int IMG_H    = 120;
  localparam int FRAME_PX = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IDLE       = 2'd1,
    BYTE1      = 2'd2,
    BYTE2      = 2'd3
  } state_t;

  // hi is the first byte of the RGB565 pair, lo the second; keep the top bits of each colour.
  function automatic logic [11:0] rgb565_to_rgb444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/cam_capture_rgb444.sv
// Camera byte-pair assembler: RGB565 pairs qualified by href become RGB444 frame-buffer writes.
// state      | meaning
// WAIT_FRAME | vertical blank or post-reset, waiting for the vsync falling edge
// IDLE       | inside a frame, between lines, no byte held
// BYTE2      | high byte held, expecting the low byte
// BYTE1      | pixel just completed, expecting the next high byte
module cam_capture_rgb444
  import cam_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          px_overflow
);

  localparam logic [AW-1:0] FRAME_END = AW'(FRAME_PX);

  state_t        state_q, state_d;
  logic          vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] pix_q, pix_d;
  logic          regw_q, regw_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          vs_rise, vs_fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= WAIT_FRAME;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      data_q       <= '0;
      hi_q         <= '0;
      ptr_q        <= '0;
      addr_q       <= '0;
      pix_q        <= '0;
      regw_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      href_q       <= href_d;
      data_q       <= data_d;
      hi_q         <= hi_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      pix_q        <= pix_d;
      regw_q       <= regw_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign vs_rise = vsync_q & ~vsync_prev_q;
  assign vs_fall = ~vsync_q & vsync_prev_q;

  always_comb begin
    vsync_d      = CAM_vsync;
    href_d       = CAM_href;
    data_d       = CAM_px_data;
    vsync_prev_d = vsync_q;
    state_d      = state_q;
    hi_d         = hi_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    pix_d        = pix_q;
    regw_d       = 1'b0;
    done_d       = 1'b0;
    ovf_d        = ovf_q;

    // ptr_q counts writes this frame, so reaching FRAME_END means the buffer is full.
    if (vs_rise) begin
      state_d = WAIT_FRAME;
      done_d  = (ptr_q == FRAME_END);
    end else begin
      unique case (state_q)
        WAIT_FRAME: begin
          if (vs_fall) begin
            state_d = IDLE;
            ptr_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        IDLE, BYTE1: begin
          if (href_q) begin
            hi_d    = data_q;
            state_d = BYTE2;
          end else begin
            state_d = IDLE;
          end
        end
        BYTE2: begin
          if (href_q) begin
            state_d = BYTE1;
            if (ptr_q == FRAME_END) begin
              ovf_d = 1'b1;
            end else begin
              regw_d = 1'b1;
              addr_d = ptr_q;
              pix_d  = rgb565_to_rgb444(hi_q, data_q);
              ptr_d  = ptr_q + AW'(1);
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end
  end

  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = pix_q;
  assign DP_RAM_regW    = regw_q;
  assign frame_done     = done_q;
  assign px_overflow    = ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Directed bench for cam_capture_rgb444: conversion vectors plus multi-cycle frame scenarios.
module tb_cam_capture_rgb444;

  localparam int AW = 15;
  localparam int DW = 12;
  localparam int NPX = 160 * 120;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          CAM_vsync = 1'b0;
  logic          CAM_href = 1'b0;
  logic [7:0]    CAM_px_data = 8'h00;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          regw, done, ovf;

  cam_capture_rgb444 #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .CAM_vsync(CAM_vsync),
    .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data),
    .DP_RAM_addr_in(addr),
    .DP_RAM_data_in(data),
    .DP_RAM_regW(regw),
    .frame_done(done),
    .px_overflow(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int lo_cyc = 0;
  int pcount = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int exp_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (regw) begin
      wa.push_back(int'(addr));
      wd.push_back(int'(data));
      wc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Reference conversion written arithmetically: R = hi>>4, G = hi[2:0]*2 + lo[7], B = lo[4:1].
  function automatic int model(input int hi, input int lo);
    int r, g, b;
    r = hi / 16;
    g = (hi % 8) * 2 + lo / 128;
    b = (lo / 2) % 16;
    return r * 256 + g * 16 + b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    CAM_href = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    CAM_href = 1'b1;
    CAM_px_data = b;
    tick();
  endtask

  task automatic send_px(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    lo_cyc = cyc;
    send_byte(lo);
  endtask

  task automatic send_line(input int npx, input int g);
    logic [7:0] hi, lo;
    for (int p = 0; p < npx; p++) begin
      hi = pcount[7:0];
      lo = pcount[14:7] ^ 8'hC3;
      exp_d.push_back(model(int'(hi), int'(lo)));
      pcount++;
      send_px(hi, lo);
    end
    gap(g);
  endtask

  task automatic start_frame();
    CAM_href = 1'b0;
    CAM_vsync = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    CAM_vsync = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic end_frame();
    CAM_href = 1'b0;
    CAM_vsync = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    exp_d.delete();
    done_cnt = 0;
    pcount = 0;
  endtask

  task automatic check_seq(input string nm, input int n);
    int ea, ed;
    ea = 0;
    ed = 0;
    for (int i = 0; i < n; i++) begin
      if (q_at(wa, i) != i) ea++;
      if (q_at(wd, i) != q_at(exp_d, i)) ed++;
    end
    check({nm, "_addr_errs"}, ea, 0);
    check({nm, "_data_errs"}, ed, 0);
  endtask

  initial begin
    vecs[0] = '{8'hF8, 8'h00, 12'hF00};
    vecs[1] = '{8'h07, 8'hE0, 12'h0F0};
    vecs[2] = '{8'h00, 8'h1F, 12'h00F};
    vecs[3] = '{8'hFF, 8'hFF, 12'hFFF};
    vecs[4] = '{8'h12, 8'h34, 12'h14A};
    vecs[5] = '{8'hA5, 8'h5A, 12'hAAD};

    // reset state
    for (int i = 0; i < 3; i++) tick();
    check("rst_addr", int'(addr), 0);
    check("rst_data", int'(data), 0);
    check("rst_regw", int'(regw), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    tick();

    // single byte pairs, each in its own frame
    for (int v = 0; v < 6; v++) begin
      clear_log();
      start_frame();
      send_px(vecs[v].hi, vecs[v].lo);
      gap(4);
      check($sformatf("vec%0d_nwr", v), wa.size(), 1);
      check($sformatf("vec%0d_addr", v), q_at(wa, 0), 0);
      check($sformatf("vec%0d_data", v), q_at(wd, 0), int'(vecs[v].exp));
      check($sformatf("vec%0d_latency", v), q_at(wc, 0) - lo_cyc, 2);
    end

    // odd-length line: fifth byte dropped, next line packs on
    clear_log();
    start_frame();
    send_px(8'h11, 8'h22);
    send_px(8'h33, 8'h44);
    send_byte(8'h55);
    gap(4);
    send_px(8'h66, 8'h77);
    send_px(8'h88, 8'h99);
    gap(4);
    check("odd_nwr", wa.size(), 4);
    check("odd_addr2", q_at(wa, 2), 2);
    check("odd_data2", q_at(wd, 2), 12'h6CB);
    check("odd_addr3", q_at(wa, 3), 3);

    // reset mid-line after 37 writes
    clear_log();
    start_frame();
    send_line(37, 0);
    send_byte(8'hAB);
    rst = 1'b0;
    CAM_px_data = 8'hCD;
    tick();
    rst = 1'b1;
    check("mid_rst_regw", int'(regw), 0);
    check("mid_rst_addr", int'(addr), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_nwr_before", wa.size(), 37);
    send_line(10, 4);
    check("mid_rst_no_writes", wa.size(), 37);
    start_frame();
    send_px(8'h12, 8'h34);
    send_px(8'hF8, 8'h00);
    gap(4);
    check("mid_rst_nwr_after", wa.size(), 39);
    check("mid_rst_restart_addr0", q_at(wa, 37), 0);
    check("mid_rst_restart_addr1", q_at(wa, 38), 1);
    check("mid_rst_restart_data", q_at(wd, 37), 12'h14A);

    // short frame gives no frame_done
    clear_log();
    start_frame();
    for (int l = 0; l < 100; l++) send_line(4, 4);
    end_frame();
    check("short_nwr", wa.size(), 400);
    check("short_done", done_cnt, 0);

    // next full frame starts at 0 and completes
    clear_log();
    start_frame();
    for (int l = 0; l < 120; l++) send_line(160, 4);
    check("full_done_early", done_cnt, 0);
    check("full_ovf", int'(ovf), 0);
    end_frame();
    check("full_nwr", wa.size(), NPX);
    check_seq("full", NPX);
    check("full_done", done_cnt, 1);

    // 121 lines: overflow after the last slot, no write past it
    clear_log();
    start_frame();
    for (int l = 0; l < 120; l++) send_line(160, 1);
    check("ovf_before_extra", int'(ovf), 0);
    send_line(160, 1);
    check("ovf_after_extra", int'(ovf), 1);
    check("ovf_nwr", wa.size(), NPX);
    check("ovf_last_addr", q_at(wa, NPX - 1), NPX - 1);
    end_frame();
    check("ovf_done", done_cnt, 1);
    check("ovf_sticky", int'(ovf), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
